mem_io_responder: RTL
=====================

// Module: mem_io_responder
// PURPOSE
//  Target side of the CPU byte bus (mem_a/mem_dout/mem_wr/mem_din/io_buffer_full).
//  Holds the 128KB program/data RAM and decodes the I/O window (a[17:16]==2'b11).
//  The I/O window provides a UART TX FIFO, a UART RX FIFO, a cycle counter and the program-stop strobe.
//  Sits in the top level beside cpu and feeds the UART serialiser.
// PARAMETERS
//  RAM_ADDR_WID  17  RAM byte-address width (2^17 bytes)
//  TX_DEPTH_LOG  4   log2 of TX FIFO depth (16 entries)
//  RX_DEPTH_LOG  4   log2 of RX FIFO depth (16 entries)
//  FULL_MARGIN   2   io_buffer_full asserts when TX free slots <= FULL_MARGIN
// PORTS
//  clk_in          in   1   system clock
//  rst_in          in   1   synchronous reset, active-high
//  cpu_a           in   32  address from CPU (mem_a); only [17:0] decoded
//  cpu_wr          in   1   1 = write, 0 = read (mem_wr)
//  cpu_wdata       in   8   write byte from CPU (mem_dout)
//  cpu_rdata       out  8   read byte to CPU (mem_din), registered
//  io_buffer_full  out  1   TX FIFO near full, registered
//  tx_data         out  8   byte to UART serialiser
//  tx_valid        out  1   tx_data valid (TX FIFO not empty)
//  tx_ready        in   1   serialiser accepts tx_data this cycle
//  rx_data         in   8   byte from UART deserialiser
//  rx_valid        in   1   push rx_data into RX FIFO
//  program_stop    out  1   sticky; set by a write to 0x30004
//  tx_overflow     out  1   sticky; a TX push was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (clk_in edge with rst_in=1):
//    - cpu_rdata=0, io_buffer_full=0, program_stop=0, tx_overflow=0.
//    - Both FIFOs are emptied (tx_valid=0) and cycle counter=0.
//    - RAM contents are not reset.
//    - Reset asserted mid-operation discards any pending read data and FIFO contents.
//  - Decode: io = (cpu_a[17:16]==2'b11); otherwise RAM index = cpu_a[RAM_ADDR_WID-1:0].
//  - Write timing: a write takes effect at the same edge; there is no wait.
//  - Read timing: the address presented in cycle N with cpu_wr=0 gives cpu_rdata valid in N+1.
//    - cpu_rdata holds its value until the next read.
//    - Back-to-back reads are fully pipelined, one byte per cycle.
//  - I/O write 0x30000: push cpu_wdata into TX if nonzero; a write of 0x00 is ignored.
//  - I/O write 0x30004: push 0x00 into TX and set program_stop.
//    - program_stop is set even if the push is dropped.
//  - TX push with FIFO full and no same-cycle pop: the byte is dropped and tx_overflow is set.
//  - TX FIFO full with a same-cycle pop: the push succeeds and the count is unchanged.
//  - I/O read 0x30000: pop the RX FIFO and return its head byte.
//    - If the RX FIFO is empty, return 0x00 and the FIFO is unchanged.
//  - I/O read 0x30004: return counter[7:0] and latch counter[31:8] into a snapshot.
//    - Reads of 0x30005/6/7 return snapshot bytes 1/2/3.
//    - The snapshot keeps the dword coherent across byte reads.
//  - Other I/O addresses: reads return 0x00; writes are ignored.
//  - Cycle counter: 32-bit, +1 every non-reset cycle, wraps 0xFFFFFFFF->0.
//    - The value sampled is the count before that edge's increment.
//  - TX drain: tx_valid = !tx_empty and tx_data = head byte.
//    - Pop when tx_valid && tx_ready (valid/ready handshake).
//    - tx_data must be stable while tx_valid && !tx_ready.
//  - RX: push when rx_valid.
//    - RX FIFO full and no same-cycle pop: the byte is dropped silently.
//    - RX push and CPU pop in the same cycle: both occur.
//  - io_buffer_full: registered as (TX free slots after this edge) <= FULL_MARGIN.
//    - The margin covers CPU writes already in flight while the flag propagates.
//  - FIFO pointers: TX_DEPTH_LOG+1 / RX_DEPTH_LOG+1 bits, wrap naturally.
//    - full = MSBs differ and remaining bits equal; empty = pointers equal.
// TESTING
//  - Write 0xA5 to 0x00010, then read 0x00010 -> cpu_rdata=0xA5 exactly one cycle after the read address.
//  - Write 'H','i',0x00 to 0x30000 with tx_ready=1 -> tx stream is 0x48,0x69 only; tx_overflow stays 0.
//  - tx_ready=0, write 15 nonzero bytes -> io_buffer_full=1 after the 14th write.
//    - 17th write sets tx_overflow; tx_ready=1 then drains exactly 16 bytes in order.
//  - Hold rst_in 1 cycle, run to counter=0x000001FF, read 0x30004..0x30007 -> bytes FF,01,00,00.
//  - Read 0x30000 with RX empty -> 0x00; push rx 0x31,0x32, read twice -> 0x31 then 0x32.
//  - Write 0x30004 -> program_stop=1 next cycle and tx emits 0x00.
//    - Then assert rst_in -> program_stop=0, tx_valid=0, cpu_rdata=0.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// ---------------------------------------------------------------------------
// | mem_io_responder_if : CPU byte bus between cpu (master) and responder    |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface mem_io_responder_if;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        io_buffer_full;

  modport master (
    output cpu_a, cpu_wr, cpu_wdata,
    input  cpu_rdata, io_buffer_full
  );

  modport slave (
    input  cpu_a, cpu_wr, cpu_wdata,
    output cpu_rdata, io_buffer_full
  );
endinterface

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ---------------------------------------------------------------------------
// | mem_io_responder : program/data RAM plus I/O window (UART FIFOs, counter) |
// | Rev 1.0                                                                  |
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_io_responder #(
  parameter int RAM_ADDR_WID = 17,
  parameter int TX_DEPTH_LOG = 4,
  parameter int RX_DEPTH_LOG = 4,
  parameter int FULL_MARGIN  = 2
) (
  input  wire                   clk_in,
  input  wire                   rst_in,
  mem_io_responder_if.slave     cpu,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  wire                   tx_ready,
  input  wire [7:0]             rx_data,
  input  wire                   rx_valid,
  output logic                  program_stop,
  output logic                  tx_overflow
);

  localparam logic [TX_DEPTH_LOG:0] c_TX_ONE   = {{TX_DEPTH_LOG{1'b0}}, 1'b1};
  localparam logic [RX_DEPTH_LOG:0] c_RX_ONE   = {{RX_DEPTH_LOG{1'b0}}, 1'b1};
  localparam logic [TX_DEPTH_LOG:0] c_TX_DEPTH = {1'b1, {TX_DEPTH_LOG{1'b0}}};
  localparam logic [TX_DEPTH_LOG:0] c_MARGIN   = (TX_DEPTH_LOG+1)'(FULL_MARGIN);
  localparam logic [15:0]           c_OFF_DATA = 16'h0000;
  localparam logic [15:0]           c_OFF_CNT0 = 16'h0004;
  localparam logic [15:0]           c_OFF_CNT1 = 16'h0005;
  localparam logic [15:0]           c_OFF_CNT2 = 16'h0006;
  localparam logic [15:0]           c_OFF_CNT3 = 16'h0007;

  logic [7:0]              r_ram [2**RAM_ADDR_WID];
  logic [7:0]              r_rdata;
  logic [31:0]             r_cnt;
  logic [23:0]             r_snap;

  logic [7:0]              r_tx_mem [2**TX_DEPTH_LOG];
  logic [TX_DEPTH_LOG:0]   r_tx_wr, r_tx_rd;
  logic                    r_ibf, r_tx_ovf, r_stop;

  logic [7:0]              r_rx_mem [2**RX_DEPTH_LOG];
  logic [RX_DEPTH_LOG:0]   r_rx_wr, r_rx_rd;

  logic                    w_io, w_io_wr, w_io_rd;
  logic [15:0]             w_off;
  logic [RAM_ADDR_WID-1:0] w_ram_idx;
  logic [7:0]              w_io_rdata;
  logic                    w_tx_req, w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [7:0]              w_tx_wdata;
  logic [TX_DEPTH_LOG:0]   w_tx_cnt, w_tx_cnt_nxt, w_tx_free;
  logic                    w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic                    w_unused;

  assign w_unused  = ^cpu.cpu_a[31:18];

  assign w_io      = (cpu.cpu_a[17:16] == 2'b11);
  assign w_io_wr   = w_io && cpu.cpu_wr;
  assign w_io_rd   = w_io && !cpu.cpu_wr;
  assign w_off     = cpu.cpu_a[15:0];
  assign w_ram_idx = cpu.cpu_a[RAM_ADDR_WID-1:0];

  // A write of 0x00 to the data port is a no-op; the stop port pushes a NUL
  assign w_tx_req   = w_io_wr && ((w_off == c_OFF_DATA && cpu.cpu_wdata != 8'h00) ||
                                  (w_off == c_OFF_CNT0));
  assign w_tx_wdata = (w_off == c_OFF_CNT0) ? 8'h00 : cpu.cpu_wdata;
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[TX_DEPTH_LOG] != r_tx_rd[TX_DEPTH_LOG]) &&
                      (r_tx_wr[TX_DEPTH_LOG-1:0] == r_tx_rd[TX_DEPTH_LOG-1:0]);
  assign w_tx_pop   = !w_tx_empty && tx_ready;
  assign w_tx_push  = w_tx_req && (!w_tx_full || w_tx_pop);
  assign w_tx_cnt   = r_tx_wr - r_tx_rd;

  always_comb begin
    w_tx_cnt_nxt = w_tx_cnt;
    if (w_tx_push && !w_tx_pop)
      w_tx_cnt_nxt = w_tx_cnt + c_TX_ONE;
    else if (!w_tx_push && w_tx_pop)
      w_tx_cnt_nxt = w_tx_cnt - c_TX_ONE;
  end

  assign w_tx_free  = c_TX_DEPTH - w_tx_cnt_nxt;

  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[RX_DEPTH_LOG] != r_rx_rd[RX_DEPTH_LOG]) &&
                      (r_rx_wr[RX_DEPTH_LOG-1:0] == r_rx_rd[RX_DEPTH_LOG-1:0]);
  assign w_rx_pop   = w_io_rd && (w_off == c_OFF_DATA) && !w_rx_empty;
  assign w_rx_push  = rx_valid && (!w_rx_full || w_rx_pop);

  always_comb begin
    w_io_rdata = 8'h00;
    case (w_off)
      c_OFF_DATA: w_io_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd[RX_DEPTH_LOG-1:0]];
      c_OFF_CNT0: w_io_rdata = r_cnt[7:0];
      c_OFF_CNT1: w_io_rdata = r_snap[7:0];
      c_OFF_CNT2: w_io_rdata = r_snap[15:8];
      c_OFF_CNT3: w_io_rdata = r_snap[23:16];
      default:    w_io_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (cpu.cpu_wr && !w_io)
      r_ram[w_ram_idx] <= cpu.cpu_wdata;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rdata <= 8'h00;
      r_cnt   <= 32'd0;
      r_snap  <= 24'd0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (!cpu.cpu_wr)
        r_rdata <= w_io ? w_io_rdata : r_ram[w_ram_idx];
      // Upper bytes are frozen so a later byte-wise read sees one coherent dword
      if (w_io_rd && w_off == c_OFF_CNT0)
        r_snap <= r_cnt[31:8];
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_tx_push)
      r_tx_mem[r_tx_wr[TX_DEPTH_LOG-1:0]] <= w_tx_wdata;
    if (w_rx_push)
      r_rx_mem[r_rx_wr[RX_DEPTH_LOG-1:0]] <= rx_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_ibf    <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_stop   <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_TX_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_TX_ONE;
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_RX_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_RX_ONE;
      if (w_tx_req && w_tx_full && !w_tx_pop)
        r_tx_ovf <= 1'b1;
      if (w_io_wr && w_off == c_OFF_CNT0)
        r_stop <= 1'b1;
      // Early warning leaves room for CPU writes already in flight
      r_ibf <= (w_tx_free <= c_MARGIN);
    end
  end

  assign cpu.cpu_rdata      = r_rdata;
  assign cpu.io_buffer_full = r_ibf;
  assign tx_valid           = !w_tx_empty;
  assign tx_data            = r_tx_mem[r_tx_rd[TX_DEPTH_LOG-1:0]];
  assign program_stop       = r_stop;
  assign tx_overflow        = r_tx_ovf;

endmodule

`default_nettype wire
